// File: rtl/mdu_ctrl.sv
// HI/LO owner and multi-cycle multiply/divide sequencer for the pipelined MIPS core.
// Results are computed at issue and held in a pending pair until the fixed latency expires.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            div0_q, div0_d;
  logic            done_q, done_d;
  logic            accept_s;
  logic [63:0]     mul_res_s;
  logic [63:0]     div_res_s;

  // Low 64 bits of the product of the extended operands give both signed and unsigned results.
  function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] ex;
    logic [63:0] ey;
    ex = {{32{sgn & x[31]}}, x};
    ey = {{32{sgn & y[31]}}, y};
    return ex * ey;
  endfunction

  // Magnitude divide then fix signs: quotient truncates toward zero, remainder follows the
  // dividend; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic        neg_x;
    logic        neg_y;
    logic [31:0] mag_x;
    logic [31:0] mag_y;
    logic [31:0] q;
    logic [31:0] r;
    neg_x = sgn & x[31];
    neg_y = sgn & y[31];
    mag_x = neg_x ? (~x + 32'd1) : x;
    mag_y = neg_y ? (~y + 32'd1) : y;
    if (mag_y == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = mag_x / mag_y;
      r = mag_x % mag_y;
    end
    if (neg_x ^ neg_y) begin
      q = ~q + 32'd1;
    end else begin
      q = q;
    end
    if (neg_x) begin
      r = ~r + 32'd1;
    end else begin
      r = r;
    end
    return {r, q};
  endfunction

  assign accept_s  = start & ~cancel & (state_q == S_IDLE);
  assign mul_res_s = mul64(a, b, op == OP_MULT);
  assign div_res_s = div64(a, b, op == OP_DIV);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU)) begin
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BUSY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  // Issue, countdown and commit; a cancelled start is dropped entirely, even mthi/mtlo
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = mul_res_s[63:32];
              pend_lo_d = mul_res_s[31:0];
              div0_d    = 1'b0;
              cnt_d     = MULT_LAST;
            end
            OP_DIV, OP_DIVU: begin
              if (b == 32'd0) begin
                div0_d = 1'b1;
              end else begin
                pend_hi_d = div_res_s[63:32];
                pend_lo_d = div_res_s[31:0];
                div0_d    = 1'b0;
              end
              cnt_d = DIV_LAST;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: cnt_d = cnt_q;
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          // Divide by zero still takes full latency and pulses done, but leaves HI/LO alone
          if (!div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
          end
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Outputs; stall covers the issue cycle so a following mfhi/mflo waits
  always_comb begin
    busy      = (state_q == S_BUSY);
    stall_req = d_is_md & ((state_q == S_BUSY) | start);
    done      = done_q;
    hi        = hi_q;
    lo        = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl, checked every cycle against a
// commit-cycle-based behavioural model of HI/LO.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic        d_is_md = 1'b0;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .d_is_md(d_is_md), .busy(busy), .stall_req(stall_req),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op commits at a known absolute edge number
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_active, m_done, m_div0;
  int          cyc = 0;
  int          m_commit = 0;
  longint      prod, sa, sb, q, r;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_active = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (cyc == m_commit) begin
          if (!m_div0) begin m_hi = m_phi; m_lo = m_plo; end
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end else if (start && !cancel) begin
        case (op)
          3'd0: begin
            prod = longint'($signed(a)) * longint'($signed(b));
            {m_phi, m_plo} = prod; m_div0 = 1'b0; m_active = 1'b1; m_commit = cyc + MC;
          end
          3'd1: begin
            prod = longint'({32'd0, a} * {32'd0, b});
            {m_phi, m_plo} = prod; m_div0 = 1'b0; m_active = 1'b1; m_commit = cyc + MC;
          end
          3'd2: begin
            m_div0 = (b == 32'd0);
            if (!m_div0) begin
              sa = longint'($signed(a)); sb = longint'($signed(b));
              q = sa / sb; r = sa % sb;
              m_plo = q[31:0]; m_phi = r[31:0];
            end
            m_active = 1'b1; m_commit = cyc + DC;
          end
          3'd3: begin
            m_div0 = (b == 32'd0);
            if (!m_div0) begin m_plo = a / b; m_phi = a % b; end
            m_active = 1'b1; m_commit = cyc + DC;
          end
          3'd4: m_hi = a;
          3'd5: m_lo = a;
          default: ;
        endcase
      end
      cyc++;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("stall_req", {31'd0, stall_req}, {31'd0, d_is_md & (m_active | start)});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic dmd);
    start = 1'b1; op = o; a = x; b = y; d_is_md = dmd; cancel = 1'b0;
    #1;
    if (dmd) chk("stall_issue", {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic dmd, input int n, input int cancel_at,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt = 0;
    issue(o, x, y, dmd);
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      cancel = (cnt == cancel_at);
      tick();
    end
    cancel = 1'b0;
    chk({name, "_busy_len"}, cnt, n);
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_stall_commit"}, {31'd0, stall_req}, 32'd0);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
    tick();
    chk({name, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #1 reset = 1'b0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    chk_en = 1'b1;

    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1, MC, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, MC, -1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, DC, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", 3'd3, 32'd7, 32'd0, 1'b1, DC, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, -1, 32'h0, 32'h8000_0000);

    // start together with cancel is dropped
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5; cancel = 1'b1; d_is_md = 1'b0;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_lo", lo, 32'h8000_0000);

    run_op("mult_cancel_mid", 3'd0, 32'd6, 32'd7, 1'b0, MC, 3, 32'd0, 32'd42);

    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    tick();
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = 3'd5; a = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset in busy cycle 4 of a divide
    issue(3'd2, 32'd100, 32'd3, 1'b0);
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    tick();
    reset = 1'b1;
    run_op("mult_after_rst", 3'd0, 32'd3, 32'd4, 1'b0, MC, -1, 32'd0, 32'd12);

    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      op      = 3'($urandom_range(0, 7));
      a       = pick();
      b       = pick();
      cancel  = ($urandom_range(0, 7) == 0);
      d_is_md = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        #2 reset = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
